// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: format codes, opcodes,
// FSM states and the default base address.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/instr_encoder_imm_scatter.sv
// Packs decoded fields and an immediate into an RV32I word, flags out-of-range immediates.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module instr_encoder_imm_scatter
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  logic fits12;
  logic fits13;
  logic fits21;

  // An immediate fits N bits when sign-extending its low N bits reproduces it.
  assign fits12 = (imm_i == {{20{imm_i[11]}}, imm_i[11:0]});
  assign fits13 = (imm_i == {{19{imm_i[12]}}, imm_i[12:0]});
  assign fits21 = (imm_i == {{11{imm_i[20]}}, imm_i[20:0]});

  always_comb begin
    instr_o = 32'h0;
    legal_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = fits12;
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = fits12;
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        legal_o = fits13 & ~imm_i[0];
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        legal_o = (imm_i[11:0] == 12'h0);
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal_o = fits21 & ~imm_i[0];
      end
      default: begin
        instr_o = 32'h0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words with byte addresses; rejects illegal immediates with an error pulse.
// Latency: 1 cycle from accepted request to out_valid_o/instr_o.
// Backpressure: held word stays stable while out_ready_i is low; in_ready_o drops until it drains.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  input  logic        last_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o,
  output logic        done_o
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] enc_instr;
  logic        enc_legal;
  logic        accept;
  logic        out_fire;
  logic        last_pending;

  instr_encoder_imm_scatter u_imm_scatter (
    .fmt_i    (fmt_i),
    .opcode_i (opcode_i),
    .rd_i     (rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .imm_i    (imm_i),
    .instr_o  (enc_instr),
    .legal_o  (enc_legal)
  );

  // The held word carries the program's last flag, so "last accepted, not yet emitted" is just that.
  assign last_pending = out_valid_q & out_last_q;
  assign out_fire     = out_valid_q & out_ready_i;
  assign accept       = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = (last_i & ~enc_legal) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if ((out_fire & out_last_q) | (accept & last_i & ~enc_legal)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o = (state_q != ST_DONE) & (~out_valid_q | out_ready_i) & ~last_pending;
    done_o     = (state_q == ST_DONE);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      instr_d     = 32'h0;
      addr_d      = BASE_ADDR;
    end else begin
      if (out_fire) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        addr_d      = addr_q + ADDR_STEP;
      end
      if (accept) begin
        if (enc_legal) begin
          out_valid_d = 1'b1;
          out_last_d  = last_i;
          instr_d     = enc_instr;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      instr_q     <= 32'h0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'h0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign instr_o     = instr_q;
  assign addr_o      = addr_q;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against an arithmetic reference encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  fmt_i = 3'd0;
  logic [6:0]  opcode_i = 7'd0;
  logic [4:0]  rd_i = 5'd0;
  logic [4:0]  rs1_i = 5'd0;
  logic [4:0]  rs2_i = 5'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [6:0]  funct7_i = 7'd0;
  logic [31:0] imm_i = 32'd0;
  logic        last_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic        done_o;

  int tests = 0;
  int fails = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          err_seen = 0;
  int          exp_err = 0;
  logic        mon_en = 1'b0;

  instr_encoder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .last_i      (last_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .instr_o     (instr_o),
    .addr_o      (addr_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk_i) begin
    if (mon_en && rst_i) begin
      if (out_valid_o && out_ready_i) got_q.push_back({instr_o, addr_o});
      if (err_o) err_seen++;
    end
  end

  // Reference encoder: bit placement by shift/mask, legality by signed numeric range.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    logic        ok;
    int          s;
    s  = $signed(imm);
    w  = 32'(op);
    ok = 1'b0;
    case (f)
      3'd0: begin
        w  = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
               | (32'(rs2) << 20) | (32'(f7) << 25);
        ok = 1'b1;
      end
      3'd1: begin
        w  = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        w  = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
               | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        w  = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
               | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
               | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
        ok = (s >= -4096) && (s <= 4095) && ((imm & 32'h1) == 32'h0);
      end
      3'd4: begin
        w  = w | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
        ok = ((imm & 32'hFFF) == 32'h0);
      end
      3'd5: begin
        w  = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
               | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
        ok = (s >= -1048576) && (s <= 1048575) && ((imm & 32'h1) == 32'h0);
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic last);
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; last_i = last;
    in_valid_i = 1'b1;
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0; flush_i = 1'b0; last_i = 1'b0; out_ready_i = 1'b1;
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    logic [32:0] r;
    logic [2:0]  rf;
    logic [6:0]  rop;
    logic [31:0] rimm;
    logic [31:0] exp_addr;
    logic        acc;
    int          n;

    // Reset values
    do_reset();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);

    // ADDI x1,x0,-1
    set_req(3'd1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    #1 chk("addi_rdy", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    chk("addi_valid", 32'(out_valid_o), 32'd1);
    chk("addi_instr", instr_o, 32'hFFF0_0093);
    chk("addi_addr", addr_o, 32'h0);
    tick();
    chk("addi_drain", 32'(out_valid_o), 32'd0);
    chk("addi_next_addr", addr_o, 32'h4);

    // BEQ then JAL back-to-back
    do_reset();
    set_req(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
    tick();
    set_req(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    chk("beq_instr", instr_o, 32'h0020_8463);
    chk("beq_addr", addr_o, 32'h0);
    #1 chk("beq_rdy", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    chk("jal_valid", 32'(out_valid_o), 32'd1);
    chk("jal_instr", instr_o, 32'h0010_00EF);
    chk("jal_addr", addr_o, 32'h4);

    // LUI legal then illegal
    do_reset();
    set_req(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
    tick();
    chk("lui_instr", instr_o, 32'h1234_52B7);
    set_req(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b0);
    tick();
    in_valid_i = 1'b0;
    chk("lui_bad_err", 32'(err_o), 32'd1);
    chk("lui_bad_cnt", 32'(err_cnt_o), 32'd1);
    chk("lui_bad_valid", 32'(out_valid_o), 32'd0);
    chk("lui_bad_addr", addr_o, 32'h4);
    tick();
    chk("err_one_cycle", 32'(err_o), 32'd0);

    // Range-boundary rejections
    do_reset();
    set_req(3'd1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    tick();
    chk("i2048_err", 32'(err_o), 32'd1);
    chk("i2048_valid", 32'(out_valid_o), 32'd0);
    set_req(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0);
    tick();
    in_valid_i = 1'b0;
    chk("b7_cnt", 32'(err_cnt_o), 32'd2);
    chk("b7_valid", 32'(out_valid_o), 32'd0);

    // Backpressure: word 1 held, word 2 waits
    do_reset();
    out_ready_i = 1'b0;
    set_req(3'd1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    set_req(3'd1, OP_OPIMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_instr", instr_o, 32'hFFF0_0093);
      chk("stall_rdy", 32'(in_ready_o), 32'd0);
      tick();
    end
    out_ready_i = 1'b1;
    #1 chk("unstall_rdy", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    chk("word2_instr", instr_o, 32'h0010_0113);
    chk("word2_addr", addr_o, 32'h4);

    // last_i, DONE, flush
    do_reset();
    set_req(3'd1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    set_req(3'd1, OP_OPIMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    tick();
    set_req(3'd1, OP_OPIMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1);
    tick();
    in_valid_i = 1'b0; last_i = 1'b0;
    chk("last_instr", instr_o, 32'h0020_0193);
    chk("last_addr", addr_o, 32'h8);
    #1 chk("last_pend_rdy", 32'(in_ready_o), 32'd0);
    tick();
    chk("done_set", 32'(done_o), 32'd1);
    set_req(3'd1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    #1 chk("done_rdy", 32'(in_ready_o), 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_done", 32'(done_o), 32'd0);
    chk("flush_addr", addr_o, 32'h0);
    tick();
    chk("post_flush_valid", 32'(out_valid_o), 32'd1);
    chk("post_flush_addr", addr_o, 32'h0);
    // flush beats a simultaneous accept and handshake
    set_req(3'd1, OP_OPIMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_win_valid", 32'(out_valid_o), 32'd0);
    chk("flush_win_addr", addr_o, 32'h0);

    // Async reset mid-stall
    out_ready_i = 1'b0;
    set_req(3'd1, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    in_valid_i = 1'b0;
    chk("stall_pre_rst", 32'(out_valid_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid_o), 32'd0);
    chk("async_rst_instr", instr_o, 32'h0);

    // Error counter saturation
    do_reset();
    set_req(3'd7, OP_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    for (int i = 0; i < 260; i++) tick();
    in_valid_i = 1'b0;
    tick();
    chk("err_sat", 32'(err_cnt_o), 32'd255);
    chk("err_sat_addr", addr_o, 32'h0);

    // Randomized stream against the reference encoder
    do_reset();
    exp_addr = 32'h0;
    mon_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid_i && ($urandom_range(0, 3) != 0)) begin
        rf = 3'($urandom_range(0, 7));
        case (rf)
          3'd0: rop = OP_OP;
          3'd1: rop = ($urandom_range(0, 2) == 0) ? OP_LOAD : (($urandom_range(0, 1) == 0) ? OP_JALR : OP_OPIMM);
          3'd2: rop = OP_STORE;
          3'd3: rop = OP_BRANCH;
          3'd4: rop = ($urandom_range(0, 1) == 0) ? OP_LUI : OP_AUIPC;
          3'd5: rop = OP_JAL;
          default: rop = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: rimm = $urandom;
          1: rimm = 32'($signed($urandom_range(0, 4200)) - 2100);
          2: rimm = 32'($signed($urandom_range(0, 10000)) - 5000);
          default: rimm = 32'($signed($urandom_range(0, 2200000)) - 1100000);
        endcase
        if ($urandom_range(0, 1) == 0) rimm[0] = 1'b0;
        if (rf == 3'd4 && $urandom_range(0, 1) == 0) rimm[11:0] = 12'h0;
        set_req(rf, rop, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                7'($urandom), rimm, 1'b0);
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      if (acc) begin
        r = ref_enc(fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
        if (r[32]) begin
          exp_q.push_back({r[31:0], exp_addr});
          exp_addr = exp_addr + 32'd4;
        end else begin
          exp_err++;
        end
      end
      tick();
      if (acc) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mon_en = 1'b0;

    chk("rand_words", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("rand_instr", got_q[i][63:32], exp_q[i][63:32]);
      chk("rand_addr", got_q[i][31:0], exp_q[i][31:0]);
    end
    chk("rand_err_pulses", 32'(err_seen), 32'(exp_err));
    chk("rand_err_cnt", 32'(err_cnt_o), (exp_err > 255) ? 32'd255 : 32'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
